// File: rtl/rr_mux_reg_arbiter.sv
// Two-requester round-robin arbiter that owns a shared muxed data register.
// Loads take IDLE -> LOAD -> DONE; a withdrawn winner request aborts in LOAD.
module rr_mux_reg_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             sel,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             busy,
  output logic             abort,
  output logic [CNT_W-1:0] load_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win_req;

  assign win_req = sel_q ? req1 : req0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      ptr_q   <= 1'b0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = LOAD;
          sel_d   = (req0 && req1) ? ptr_q : req1;
        end
      end
      LOAD: begin
        if (win_req) begin
          q_d     = sel_q ? d1 : d0;
          ptr_d   = ~sel_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant and abort are qualified by rst so an interrupted load never grants.
  always_comb begin
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    abort = 1'b0;
    valid = (state_q == DONE);
    busy  = (state_q != IDLE);
    if (state_q == LOAD && !rst) begin
      gnt0  = !sel_q && req0;
      gnt1  = sel_q && req1;
      abort = !win_req;
    end
  end

  assign sel      = sel_q;
  assign q        = q_q;
  assign load_cnt = cnt_q;

endmodule

// File: tb/tb_rr_mux_reg_arbiter.sv
// Directed plus random bench for rr_mux_reg_arbiter against a
// timestamp-based transaction model.
module tb_rr_mux_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] d0, d1;
  logic       sel, gnt0, gnt1, valid, busy, abort;
  logic [7:0] q;
  logic [3:0] load_cnt;

  rr_mux_reg_arbiter #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .d0(d0), .d1(d1),
    .sel(sel), .gnt0(gnt0), .gnt1(gnt1),
    .q(q), .valid(valid), .busy(busy),
    .abort(abort), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Model: a load accepted at an edge owns the next cycle (grant window)
  // and, unless withdrawn, the cycle after (valid window).
  int         cyc = 0;
  int         acc = -10;
  int         m_win = 0;
  int         m_ptr = 0;
  int         m_sel = 0;
  int         m_cnt = 0;
  bit         m_ab = 0;
  logic [7:0] m_q = 8'h00;

  logic [7:0] vq[$];
  bit         ab_seen;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step(input logic r, input logic a, input logic b,
                      input logic [7:0] x, input logic [7:0] y);
    bit in_load, in_done, rq;
    rst = r; req0 = a; req1 = b; d0 = x; d1 = y;
    #1;
    in_load = (cyc == acc);
    in_done = (cyc == acc + 1) && !m_ab;
    rq = (m_win == 1) ? b : a;
    chk("gnt0", gnt0, in_load && m_win == 0 && a && !r);
    chk("gnt1", gnt1, in_load && m_win == 1 && b && !r);
    chk("abort", abort, in_load && !rq && !r);
    chk("valid", valid, in_done);
    chk("busy", busy, in_load || in_done);
    chk("sel", sel, m_sel);
    chk("q", q, m_q);
    chk("load_cnt", load_cnt, m_cnt);
    if (valid) vq.push_back(q);
    if (abort) ab_seen = 1;
    @(posedge clk);
    if (r) begin
      acc = -10; m_ptr = 0; m_sel = 0; m_cnt = 0; m_q = 8'h00; m_ab = 0;
    end else if (in_load) begin
      if (rq) begin
        m_q   = (m_win == 1) ? y : x;
        m_ptr = 1 - m_win;
        m_cnt = (m_cnt + 1) % 16;
      end else begin
        m_ab = 1;
      end
    end else if (!in_done && (a || b)) begin
      m_win = (a && b) ? m_ptr : (b ? 1 : 0);
      m_sel = m_win;
      acc   = cyc + 1;
      m_ab  = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] r8;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    @(posedge clk);
    @(negedge clk);

    // reset held with a pending request
    step(1, 1, 0, 8'hA5, 8'h00);
    step(1, 1, 0, 8'hA5, 8'h00);
    chk("rst_q", q, 8'h00);
    chk("rst_busy", busy, 1'b0);
    step(0, 1, 0, 8'hA5, 8'h00);
    step(0, 1, 0, 8'hA5, 8'h00);
    step(0, 0, 0, 8'hA5, 8'h00);
    chk("first_q", q, 8'hA5);

    // single requester 0
    step(0, 1, 0, 8'h3C, 8'h00);
    step(0, 1, 0, 8'h3C, 8'h00);
    step(0, 0, 0, 8'h3C, 8'h00);
    chk("r0_q", q, 8'h3C);
    chk("r0_cnt", load_cnt, 4'd2);

    // single requester 1
    step(0, 0, 1, 8'h00, 8'hC3);
    step(0, 0, 1, 8'h00, 8'hC3);
    step(0, 0, 0, 8'h00, 8'hC3);
    chk("r1_q", q, 8'hC3);
    chk("r1_sel", sel, 1'b1);

    // both held: strict alternation
    vq.delete();
    for (int i = 0; i < 12; i++) step(0, 1, 1, 8'h11, 8'h22);
    step(0, 0, 0, 8'h11, 8'h22);
    chk("alt_n", vq.size(), 4);
    if (vq.size() == 4) begin
      chk("alt0", vq[0], 8'h11);
      chk("alt1", vq[1], 8'h22);
      chk("alt2", vq[2], 8'h11);
      chk("alt3", vq[3], 8'h22);
    end

    // abort: one-cycle req1
    ab_seen = 0;
    step(0, 0, 1, 8'h00, 8'h99);
    step(0, 0, 0, 8'h00, 8'h99);
    step(0, 0, 0, 8'h00, 8'h99);
    chk("ab_seen", ab_seen, 1'b1);
    chk("ab_q", q, 8'h22);
    chk("ab_cnt", load_cnt, 4'd7);
    vq.delete();
    step(0, 1, 1, 8'h44, 8'h55);
    step(0, 1, 1, 8'h44, 8'h55);
    step(0, 0, 0, 8'h44, 8'h55);
    chk("ab_ptr_q", q, 8'h44);

    // reset during LOAD
    vq.delete();
    step(0, 1, 0, 8'h77, 8'h00);
    step(1, 1, 0, 8'h77, 8'h00);
    step(0, 0, 0, 8'h77, 8'h00);
    chk("midrst_q", q, 8'h00);
    chk("midrst_nv", vq.size(), 0);

    // 16 loads wrap the counter
    for (int i = 0; i < 16; i++) begin
      r8 = 8'($urandom);
      step(0, 1, 0, r8, 8'h00);
      step(0, 1, 0, r8, 8'h00);
      step(0, 0, 0, r8, 8'h00);
    end
    chk("wrap_cnt", load_cnt, 4'd0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 40) == 0, 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
